// File: rtl/down_count_timer.sv
// Loadable down-counter/timer: counts a stored period to zero on enabled cycles,
// pulses tc on expiry, then stops (one-shot) or reloads the period (periodic).
module down_count_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             restart,
  input  logic             enable,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             tc_q, tc_d;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    period_d = period_q;
    tc_d     = 1'b0;

    if (load) begin
      period_d = load_value;
      count_d  = load_value;
      state_d  = (load_value != '0) ? RUN : IDLE;
    end else if (restart) begin
      count_d = period_q;
      state_d = (period_q != '0) ? RUN : IDLE;
    end else if (state_q == RUN && enable) begin
      if (count_q > ONE) begin
        count_d = count_q - ONE;
      end else if (count_q == ONE) begin
        count_d = '0;
        tc_d    = 1'b1;
        if (!auto_reload) state_d = IDLE;
      end else begin
        // The zero cycle of a periodic run: reload, or stop if the mode was switched to one-shot.
        if (auto_reload) count_d = period_q;
        else             state_d = IDLE;
      end
    end
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      period_q <= '0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      period_q <= period_d;
      tc_q     <= tc_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign busy  = (state_q == RUN);

endmodule

// File: doc/down_count_timer.md
# down_count_timer

Loadable, programmable down-counter and timer: the counting counterpart to the design's free-running up-counter. Counts a registered period down to zero on enabled clock cycles, flags expiry with a one-cycle terminal-count pulse, and either stops (one-shot) or reloads the period (periodic). Sits beside the latch/flip-flop test structures in the top level, supplying timed events and divided strobes from the fast or slow clock.

## Interface
- WIDTH, 8: width of count, period and load_value.
- Clk  input  1  clock; all state changes on posedge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- load  input  1  sample load_value into period and count; highest synchronous priority.
- load_value  input  WIDTH  new period, unsigned.
- restart  input  1  reload count from the stored period and start; ignored when load=1.
- enable  input  1  count-advance qualifier; no change when low.
- auto_reload  input  1  1 = periodic, 0 = one-shot.
- count  output  WIDTH  current count value.
- tc  output  1  terminal-count pulse, registered.
- busy  output  1  high while state is RUN.

## Operation
- Registers: count, period, state {IDLE, RUN}, tc. busy = (state == RUN), combinational from state.
- Reset (async): count=0, period=0, state=IDLE, tc=0, so busy=0.
- Priority per posedge: load > restart > enabled counting > hold.
- load=1:
  - period<=load_value, count<=load_value, tc<=0.
  - state<=RUN if load_value!=0, else IDLE.
  - Applies in any state; a load mid-run restarts cleanly.
- restart=1, load=0:
  - count<=period, tc<=0.
  - state<=RUN if period!=0, else IDLE with count 0.
- IDLE, no load/restart: count holds, tc<=0. enable has no effect.
- RUN, enable=1:
  - count>1: count<=count-1, tc<=0.
  - count==1: count<=0, tc<=1. If auto_reload=0, state<=IDLE. If auto_reload=1, state stays RUN.
  - count==0 (periodic only): if auto_reload=1, count<=period and tc<=0. If auto_reload=0, state<=IDLE, count stays 0, tc<=0.
- RUN, enable=0: count and state hold, tc<=0. tc is never high for more than one cycle.
- Arithmetic: unsigned, WIDTH bits. Decrement never wraps, because 0 is never decremented.
- The maximum period is 2^WIDTH-1.

## Timing
- Load latency: count equals load_value in the cycle after the load edge; busy rises in that same cycle.
- One-shot, P loaded, enable held high:
  - count shows P, P-1, ..., 1, 0 on the P edges after load.
  - tc=1 and busy=0 in the same cycle that count first shows 0.
- Periodic, P loaded, enable held high:
  - Sequence P..1, 0, P..1, 0; period is P+1 cycles.
  - tc=1 exactly in cycles where count==0.
  - P=1 gives tc every 2nd cycle.
- enable gaps stretch the count; each enabled cycle advances exactly one step.
- load_value=0 or restart with period=0: no tc, busy stays 0.
- reset asserted mid-run: outputs clear without waiting for Clk. On release, the block stays IDLE until load.
- load and restart in the same cycle: load wins.
- load in the same cycle as a 1→0 step: load wins and tc stays 0.

## Test plan
- Reset, then load=1, load_value=3, enable=1, auto_reload=0 -> count 3,2,1,0; tc=1 only in the count=0 cycle; busy falls with it; count holds 0 afterwards.
- load_value=2, auto_reload=1, enable=1 for 9 cycles -> count 2,1,0,2,1,0,2,1,0; tc high in exactly 3 isolated cycles.
- load_value=4, enable toggled 1,0,1,0,... -> count steps only on enabled cycles; tc lasts one cycle even if enable drops right after 0.
- Mid-run at count=2: load_value=5 -> count=5 next cycle, tc=0. Then restart at count=3 -> count=5. Then load_value=0 -> IDLE, busy=0, no tc.
- Assert reset asynchronously between clock edges with count=7 in RUN -> count=0, tc=0, busy=0 before the next Clk edge. After release, enable=1 alone leaves count at 0.
- WIDTH=8, load_value=255, one-shot -> tc after exactly 255 enabled cycles, no wrap. restart afterwards repeats 255 without a new load.
